// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 receiver with make/break key tracking, press counter and sticky frame error.
// Optional ASCII translation of the held key is compiled in when PS2_ASCII_EN is defined.
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic [7:0] press_cnt,
`ifdef PS2_ASCII_EN
    output logic [7:0] ascii,
`endif
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BREAK = 1'b1} state_t;

    logic [2:0]    ps2_clk_sync_r;
    logic [1:0]    ps2_data_sync_r;
    logic          fall_s;
    logic          data_bit_s;
    logic [10:0]   shift_r;
    logic [10:0]   frame_s;
    logic          frame_ok_s;
    logic [3:0]    bit_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          byte_valid_r;
    logic [7:0]    byte_r;
    state_t        state_r;

    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] set2_to_ascii(input logic [7:0] c);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction
`endif

    // Pin synchronisers; bit 2 of the clock chain is the previous sample for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_sync_r  <= 3'b000;
            ps2_data_sync_r <= 2'b00;
        end else begin
            ps2_clk_sync_r  <= {ps2_clk_sync_r[1:0], ps2_clk};
            ps2_data_sync_r <= {ps2_data_sync_r[0], ps2_data};
        end
    end

    assign fall_s     = ps2_clk_sync_r[2] & ~ps2_clk_sync_r[1];
    assign data_bit_s = ps2_data_sync_r[1];
    // Frame as it will look once the current (stop) bit is shifted in; frame_s[0] is the start bit
    assign frame_s    = {data_bit_s, shift_r[10:1]};
    assign frame_ok_s = (frame_s[0] == 1'b0) && (frame_s[10] == 1'b1) &&
                        odd_parity_ok(frame_s[9:1]);

    // Bit receiver, frame check and inactivity timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r      <= 11'd0;
            bit_cnt_r    <= 4'd0;
            tmo_cnt_r    <= '0;
            byte_valid_r <= 1'b0;
            byte_r       <= 8'd0;
            frame_err    <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            if (fall_s) begin
                tmo_cnt_r <= '0;
                shift_r   <= frame_s;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (frame_ok_s) begin
                        byte_valid_r <= 1'b1;
                        byte_r       <= frame_s[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (tmo_cnt_r == TMO_LAST) begin
                    bit_cnt_r <= 4'd0;
                    tmo_cnt_r <= '0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + 1'b1;
                end
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    // Make/break tracker; E0 prefixes are dropped so extended keys look like plain codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            key_code  <= 8'd0;
            key_valid <= 1'b0;
            press_cnt <= 8'd0;
`ifdef PS2_ASCII_EN
            ascii     <= 8'd0;
`endif
        end else if (byte_valid_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (byte_r == 8'hF0) begin
                        state_r <= ST_BREAK;
                    end else if (byte_r == 8'hE0) begin
                        state_r <= ST_IDLE;
                    end else if (!key_valid || (byte_r != key_code)) begin
                        key_code  <= byte_r;
                        key_valid <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
`ifdef PS2_ASCII_EN
                        ascii     <= set2_to_ascii(byte_r);
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (byte_r == key_code) begin
                        key_valid <= 1'b0;
                    end else begin
                        key_valid <= key_valid;
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random byte streams
// compared against a make/break reference model. Define PS2_ASCII_EN to also check ascii.
module tb_ps2_key_tracker;
    localparam int TMO = 64;
    localparam int H   = 5;

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data;
    logic [7:0] key_code, press_cnt;
    logic       key_valid, frame_err;
`ifdef PS2_ASCII_EN
    logic [7:0] ascii;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_code, m_cnt, m_ascii;
    logic       m_valid, m_err, m_brk;

    always #10 clk = ~clk;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .press_cnt (press_cnt),
`ifdef PS2_ASCII_EN
        .ascii     (ascii),
`endif
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (LETTERS[i] == c) return 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (DIGITS[i] == c) return 8'(8'h30 + i);
        return 8'h00;
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_cnt = 8'h00; m_ascii = 8'h00;
        m_valid = 1'b0; m_err = 1'b0; m_brk = 1'b0;
    endtask

    // Reference behaviour: one received frame at a time
    task automatic model_apply(input logic [7:0] b, input logic bad);
        if (bad) m_err = 1'b1;
        else if (m_brk) begin
            if (b == m_code) m_valid = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_brk = 1'b0;
        else if (!m_valid || b != m_code) begin
            m_code = b; m_valid = 1'b1; m_cnt = m_cnt + 8'd1; m_ascii = to_ascii(b);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".code"}, key_code, m_code);
        check({tag, ".valid"}, key_valid, m_valid);
        check({tag, ".cnt"}, press_cnt, m_cnt);
        check({tag, ".err"}, frame_err, m_err);
`ifdef PS2_ASCII_EN
        check({tag, ".ascii"}, ascii, m_ascii);
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nb);
        for (int i = 0; i < nb; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad, input string tag);
        send_bits(mk(b, bad), 11);
        tick(12);
        model_apply(b, bad);
        check_all(tag);
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        int          r;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        tick(3);
        check("rst.code", key_code, 8'h00);
        check("rst.valid", key_valid, 1'b0);
        check("rst.cnt", press_cnt, 8'h00);
        check("rst.err", frame_err, 1'b0);
        rst = 1'b0;
        tick(5);

        // First frame, with exact output latency relative to the stop-bit pin edge
        f = mk(8'h1C, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        tick(H);
        ps2_clk = 1'b0;
        tick(3);
        check("lat.early_valid", key_valid, 1'b0);
        check("lat.early_cnt", press_cnt, 8'h00);
        tick(1);
        check("lat.code", key_code, 8'h1C);
        check("lat.valid", key_valid, 1'b1);
        check("lat.cnt", press_cnt, 8'h01);
        check("lat.err", frame_err, 1'b0);
`ifdef PS2_ASCII_EN
        check("lat.ascii", ascii, 8'h41);
`endif
        tick(H - 4);
        ps2_clk = 1'b1;
        tick(12);
        model_apply(8'h1C, 1'b0);

        // Typematic repeats and release
        send_byte(8'h1C, 1'b0, "rep1");
        send_byte(8'h1C, 1'b0, "rep2");
        check("rep.cnt", press_cnt, 8'h01);
        send_byte(8'hF0, 1'b0, "brk.f0");
        send_byte(8'h1C, 1'b0, "brk.1c");
        check("brk.valid", key_valid, 1'b0);
        check("brk.code", key_code, 8'h1C);

        // Rollover: second key pressed while first still held
        send_byte(8'h1C, 1'b0, "roll.1c");
        send_byte(8'h32, 1'b0, "roll.32");
        send_byte(8'hF0, 1'b0, "roll.f0a");
        send_byte(8'h1C, 1'b0, "roll.rel1c");
        check("roll.cnt", press_cnt, 8'h03);
        check("roll.code", key_code, 8'h32);
        check("roll.held", key_valid, 1'b1);
        send_byte(8'hF0, 1'b0, "roll.f0b");
        send_byte(8'h32, 1'b0, "roll.rel32");
        check("roll.released", key_valid, 1'b0);

        // Partial frame abandoned by timeout
        send_bits(mk(8'h45, 1'b0), 5);
        tick(TMO + 20);
        send_byte(8'h1C, 1'b0, "tmo");
        check("tmo.code", key_code, 8'h1C);
        check("tmo.err", frame_err, 1'b0);

        // Parity error is sticky and produces no byte
        send_byte(8'h1C, 1'b1, "par.bad");
        check("par.err", frame_err, 1'b1);
        check("par.cnt", press_cnt, 8'h04);
        send_byte(8'h45, 1'b0, "par.next");
        check("par.next_code", key_code, 8'h45);
        check("par.err_sticky", frame_err, 1'b1);

        // Asynchronous reset in the middle of a frame
        send_bits(mk(8'h24, 1'b0), 5);
        rst = 1'b1;
        #2;
        check("arst.code", key_code, 8'h00);
        check("arst.valid", key_valid, 1'b0);
        check("arst.cnt", press_cnt, 8'h00);
        check("arst.err", frame_err, 1'b0);
`ifdef PS2_ASCII_EN
        check("arst.ascii", ascii, 8'h00);
`endif
        tick(1);
        rst = 1'b0;
        ps2_data = 1'b1;
        model_reset();
        tick(5);
        send_byte(8'h24, 1'b0, "arst.next");
        check("arst.next_code", key_code, 8'h24);
        check("arst.next_cnt", press_cnt, 8'h01);

        // Counter wrap: 255 more distinct presses bring the count to 256 -> 0
        send_byte(8'hF0, 1'b0, "wrap.f0");
        send_byte(8'h24, 1'b0, "wrap.rel");
        for (int i = 0; i < 255; i++)
            send_byte(i[0] ? 8'h32 : 8'h1C, 1'b0, "wrap");
        check("wrap.cnt", press_cnt, 8'h00);

        // Random byte streams with occasional corrupted frames
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r < 6) begin
                r = int'($urandom_range(0, 2));
                b = (r == 0) ? 8'h1C : ((r == 1) ? 8'h32 : 8'h45);
            end else b = 8'($urandom_range(0, 255));
            send_byte(b, ($urandom_range(0, 11) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Upstream stage of the keyboard display path. Receives PS/2 keyboard frames and decodes make/break scan codes (set 2).
- Holds the currently pressed key and a running count of key presses.
- Top level splits key_code and press_cnt into nibbles for the per-digit seven-segment decoders. key_valid drives their enable, so the key digits blank when no key is held.

Parameters:
TIMEOUT_CYCLES, 10000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (0.2 ms at 50 MHz).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ps2_clk  input  1  PS/2 clock pin, asynchronous to clk
ps2_data  input  1  PS/2 data pin, asynchronous to clk
key_code  output  8  scan code of last pressed key, held after release
key_valid  output  1  1 while key_code is held down
press_cnt  output  8  number of distinct presses, wraps 255->0
frame_err  output  1  sticky: start/stop/parity error seen since reset

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0, the FSM is IDLE, and the bit counter, shift register, timeout counter and synchronisers are cleared. Reset mid-frame discards the partial frame; reception restarts at the next start bit after release.
- Synchroniser: ps2_clk and ps2_data each pass through 2 flops. A third history flop on ps2_clk gives the edge detect. fall = prev & ~cur, a 1-cycle strobe. Data is sampled from the synchronised ps2_data in the same cycle as fall.
- Receiver:
  - 11-bit frame, LSB first: start(0), d[7:0], parity (odd), stop(1).
  - On each fall, shift the data bit in and increment bit_cnt 0..10.
  - On the fall at bit_cnt==10, check start==0, stop==1 and ^{d,parity}==1.
    - All pass: byte_valid pulses 1 cycle later carrying d.
    - Any fail: frame_err is set, no byte is produced.
  - bit_cnt returns to 0 in both cases.
- Timeout: counter clears on every fall and counts while bit_cnt!=0. On reaching TIMEOUT_CYCLES, bit_cnt goes to 0 silently (frame_err unchanged).
- Tracker FSM, states IDLE and BREAK, acts only on byte_valid:
  - IDLE, byte F0: go to BREAK.
  - IDLE, byte E0: ignore, stay IDLE (extended prefix; next byte is treated as a plain code).
  - IDLE, other byte, key_valid==0 or byte!=key_code: key_code<=byte, key_valid<=1, press_cnt<=press_cnt+1 (8-bit wrap).
  - IDLE, byte==key_code and key_valid==1: typematic repeat, no change.
  - BREAK, any byte: if byte==key_code, key_valid<=0; key_code retained. Return to IDLE. Break of a non-current key changes no output.
- Latency: all key outputs update on the clock edge 1 cycle after byte_valid, i.e. 2 cycles after the stop-bit fall strobe (4–5 clk after the pin edge, synchroniser uncertainty).
- frame_err clears only on rst.
- No backpressure. Bytes arrive at most every ~11 PS/2 bit times, so no buffering is required.

Optional Feature:
- Macro: PS2_ASCII_EN.
- Defined:
  - Adds output port ascii, 8 bits.
  - Registered in the same cycle as key_code.
  - Maps set-2 codes of A–Z to 0x41–0x5A and 0–9 (main row) to 0x30–0x39; all other codes map to 0x00.
  - Reset value 0x00.
  - Unchanged on repeat or break.
- Undefined: the port and lookup logic are absent; all other behaviour is identical.

Test Plan:
- Frame 0x1C, valid parity, 20 kHz PS/2 clock, clk 50 MHz -> 2 cycles after stop fall strobe: key_code=0x1C, key_valid=1, press_cnt=1, frame_err=0; with PS2_ASCII_EN, ascii=0x41.
- Frames 1C,1C,1C then F0,1C -> press_cnt stays 1 through repeats; after F0 1C: key_valid=0, key_code=0x1C.
- Press 0x1C, press 0x32 without release, then F0 1C -> press_cnt=2, key_code=0x32, key_valid stays 1; then F0 32 -> key_valid=0.
- Frame 0x1C with parity bit flipped -> frame_err=1, key_code/key_valid/press_cnt unchanged. Next good frame 0x45 -> key_code=0x45, frame_err still 1.
- Send 5 bits, stall ps2_clk high > TIMEOUT_CYCLES, then full frame 0x1C -> key_code=0x1C, frame_err=0.
- Assert rst for 1 cycle mid-frame after key 0x1C held -> all outputs 0 immediately (async). Next full frame 0x24 -> key_code=0x24, press_cnt=1.
- Press/release 256 distinct presses (alternate 1C/32) -> press_cnt wraps to 0.
